pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the pipelined MIPS32 datapath. It is the successor to the fixed IF/ID and ID/EX latches. It carries a control bundle and a data bundle with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never creates a combinational ready path. It also supports synchronous flush (bubble insertion), an upstream hold, and saturating performance counters, and is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 98 +++++++++
 tb/tb_pipe_stage_skid.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with 2-entry skid (main drives out_*), flush, hold, occupancy and saturating xfer/bubble/flush counters
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic in_fire, out_fire, load_in, load_skid, pop_skid;
  logic [1:0] flush_add;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  assign in_ready  = (state != SKID) & !hold;
  assign out_valid = state != EMPTY;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign flush_add = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
  always_comb begin
    state_nx  = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_nx = FULL;
        load_in  = 1'b1;
      end
      FULL: if (in_fire & out_fire) load_in = 1'b1;
        else if (in_fire) begin
          state_nx  = SKID;
          load_skid = 1'b1;
        end else if (out_fire) state_nx = EMPTY;
      SKID: if (out_fire) begin
        state_nx = FULL;
        pop_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx  = EMPTY;
      load_in   = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nx;
      main_ctrl <= load_in ? in_ctrl : pop_skid ? skid_ctrl : main_ctrl;
      main_data <= load_in ? in_data : pop_skid ? skid_data : main_data;
      skid_ctrl <= load_skid ? in_ctrl : skid_ctrl;
      skid_data <= load_skid ? in_data : skid_data;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || clr_cnt) begin
      xfer_cnt   <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      xfer_cnt   <= sat_add(xfer_cnt, {1'b0, out_fire});
      bubble_cnt <= sat_add(bubble_cnt, {1'b0, !out_valid & out_ready});
      flush_cnt  <= flush ? sat_add(flush_cnt, flush_add) : flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of streaming, back-pressure, flush, hold, saturation and async reset
module tb_pipe_stage_skid;
  localparam int DATA_W = 64, CTRL_W = 12, CNT_W = 4;
  logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, hold, flush, clr_cnt;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] xfer_cnt, bubble_cnt, flush_cnt;
  int tests = 0, fails = 0;
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .hold(hold), .flush(flush), .clr_cnt(clr_cnt), .occupancy(occupancy),
    .xfer_cnt(xfer_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [11:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask
  task automatic clear();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask
  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hold = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_ctrl = '0; in_data = '0;
    #3;
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_ovalid", 64'(out_valid), 0);
    chk("rst_octrl", 64'(out_ctrl), 0);
    chk("rst_odata", out_data, 0);
    chk("rst_xfer", 64'(xfer_cnt), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    hold = 1'b1;
    #1 chk("rst_hold_in_ready", 64'(in_ready), 0);
    hold = 1'b0;
    step();
    #3 reset = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(12'(i), 64'(i));
      step();
      chk($sformatf("stream_valid%0d", i), 64'(out_valid), 1);
      chk($sformatf("stream_ctrl%0d", i), 64'(out_ctrl), 64'(i));
      chk($sformatf("stream_data%0d", i), out_data, 64'(i));
      chk($sformatf("stream_occ%0d", i), 64'(occupancy), 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(occupancy), 0);
    chk("stream_xfer", 64'(xfer_cnt), 8);
    out_ready = 1'b0;
    clear();
    chk("clr_xfer", 64'(xfer_cnt), 0);
    chk("clr_bubble", 64'(bubble_cnt), 0);
    push(12'hA1, 64'hAAAA);
    step();
    chk("bp_full_occ", 64'(occupancy), 1);
    push(12'hB2, 64'hBBBB);
    step();
    chk("bp_skid_occ", 64'(occupancy), 2);
    chk("bp_skid_in_ready", 64'(in_ready), 0);
    chk("bp_skid_ctrl_a", 64'(out_ctrl), 64'hA1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 chk("bp_out_a_data", out_data, 64'hAAAA);
    step();
    chk("bp_out_b_ctrl", 64'(out_ctrl), 64'hB2);
    chk("bp_out_b_data", out_data, 64'hBBBB);
    chk("bp_out_b_occ", 64'(occupancy), 1);
    step();
    chk("bp_empty_valid", 64'(out_valid), 0);
    chk("bp_empty_ctrl", 64'(out_ctrl), 0);
    chk("bp_hold_data", out_data, 64'hBBBB);
    chk("bp_xfer", 64'(xfer_cnt), 2);
    out_ready = 1'b0;
    clear();
    push(12'hC3, 64'hC);
    step();
    push(12'hD4, 64'hD);
    step();
    push(12'hE5, 64'hE);
    flush = 1'b1;
    #1 chk("fl_skid_in_ready", 64'(in_ready), 0);
    step();
    flush = 1'b0;
    chk("fl_skid_occ", 64'(occupancy), 0);
    chk("fl_skid_valid", 64'(out_valid), 0);
    chk("fl_skid_ctrl", 64'(out_ctrl), 0);
    chk("fl_skid_cnt", 64'(flush_cnt), 2);
    push(12'hF6, 64'hF);
    step();
    push(12'h117, 64'h11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_full_occ", 64'(occupancy), 0);
    chk("fl_full_cnt", 64'(flush_cnt), 4);
    push(12'h128, 64'h12);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_xfer_cnt", 64'(flush_cnt), 4);
    chk("fl_xfer_xfer", 64'(xfer_cnt), 1);
    out_ready = 1'b0;
    clear();
    push(12'h139, 64'h13);
    step();
    push(12'h14A, 64'h14);
    hold = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("hold_in_ready%0d", i), 64'(in_ready), 0);
      step();
    end
    chk("hold_occ", 64'(occupancy), 0);
    chk("hold_xfer", 64'(xfer_cnt), 1);
    chk("hold_bubble", 64'(bubble_cnt), 2);
    hold = 1'b0;
    in_valid = 1'b0;
    #1 chk("hold_release_in_ready", 64'(in_ready), 1);
    out_ready = 1'b0;
    clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      push(12'(i), 64'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_xfer", 64'(xfer_cnt), 15);
    push(12'h155, 64'h55);
    step();
    in_valid = 1'b0;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("sat_clr_xfer", 64'(xfer_cnt), 0);
    chk("sat_clr_occ", 64'(occupancy), 0);
    push(12'h161, 64'h61);
    step();
    push(12'h162, 64'h62);
    step();
    push(12'h163, 64'h63);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", 64'(occupancy), 2);
    chk("ar_pre_xfer", 64'(xfer_cnt), 1);
    #3 reset = 1'b0;
    #1;
    chk("ar_occ", 64'(occupancy), 0);
    chk("ar_valid", 64'(out_valid), 0);
    chk("ar_ctrl", 64'(out_ctrl), 0);
    chk("ar_data", out_data, 0);
    chk("ar_xfer", 64'(xfer_cnt), 0);
    step();
    #3 reset = 1'b1;
    step();
    chk("ar_post_occ", 64'(occupancy), 0);
    chk("ar_post_in_ready", 64'(in_ready), 1);
    chk("ar_post_valid", 64'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
